// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage divider.
// State encoding, default width and constants.
package div_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BYZERO = 2'b01;
    localparam logic [1:0] ON     = 2'b10;
    localparam logic [1:0] END    = 2'b11;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Shifts {rem, quo} left and conditionally subtracts the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shr;
    logic [WIDTH:0] w_diff;

    // Extra bit keeps the shifted remainder exact before the compare
    assign w_shr  = {i_rem, i_quo[WIDTH-1]};
    assign w_diff = w_shr - {1'b0, i_dvs};

    always_comb begin
        if (w_diff[WIDTH]) begin
            o_rem = w_shr[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end else begin
            o_rem = w_diff[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in EX.
// Optional DIV_EARLY_TERM_EN: skip iterations when |dividend| < |divisor|.
module ex_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             cpu_clk_75M,
    input  logic             cpu_rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             flush_i,
    output logic             stop_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [1:0]       r_state;
    logic [1:0]       w_nstate;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_dd_neg;
    logic             w_dv_neg;
    logic [WIDTH-1:0] w_dd_mag;
    logic [WIDTH-1:0] w_dv_mag;
    logic             w_dv_zero;
    logic             w_early;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;

    assign w_dd_neg  = signed_i & dividend_i[WIDTH-1];
    assign w_dv_neg  = signed_i & divisor_i[WIDTH-1];
    assign w_dd_mag  = w_dd_neg ? -dividend_i : dividend_i;
    assign w_dv_mag  = w_dv_neg ? -divisor_i : divisor_i;
    assign w_dv_zero = (divisor_i == '0);
    assign w_accept  = (r_state == IDLE) & start_i & ~flush_i;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_TERM_EN
    assign w_early = ~w_dv_zero & (w_dd_mag < w_dv_mag);
`else
    assign w_early = 1'b0;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    always_ff @(posedge cpu_clk_75M) begin
        if (cpu_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_comb begin
        w_nstate = r_state;
        if (flush_i) begin
            w_nstate = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        if (w_dv_zero) begin
                            w_nstate = BYZERO;
                        end else if (w_early) begin
                            w_nstate = END;
                        end else begin
                            w_nstate = ON;
                        end
                    end
                end
                BYZERO: w_nstate = END;
                ON: begin
                    if (w_last) begin
                        w_nstate = END;
                    end
                end
                END: w_nstate = IDLE;
                default: w_nstate = IDLE;
            endcase
        end
    end

    // END deliberately drops the stall so the pipeline advances with the result
    always_comb begin
        stop_o  = 1'b0;
        ready_o = 1'b0;
        if (!flush_i) begin
            unique case (r_state)
                IDLE:    stop_o  = start_i;
                BYZERO:  stop_o  = 1'b1;
                ON:      stop_o  = 1'b1;
                END:     ready_o = 1'b1;
                default: stop_o  = 1'b0;
            endcase
        end
    end

    always_ff @(posedge cpu_clk_75M) begin
        if (cpu_rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= w_dd_mag;
            r_dvs  <= w_dv_mag;
            r_qneg <= w_dd_neg ^ w_dv_neg;
            r_rneg <= w_dd_neg;
            if (w_early) begin
                r_hi <= dividend_i;
                r_lo <= '0;
            end
        end else if (r_state == ON && !flush_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
            // Results land on the final step so they are valid in END
            if (w_last) begin
                r_hi <= r_rneg ? -w_step_rem : w_step_rem;
                r_lo <= r_qneg ? -w_step_quo : w_step_quo;
            end
        end else if (r_state == BYZERO && !flush_i) begin
            r_hi <= WIDTH'(ZERO_WORD);
            r_lo <= WIDTH'(ZERO_WORD);
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div.
// Expected values are hand-computed constants.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        flush;
    logic        stop;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_run;
    int n_fail;

    ex_div dut (
        .cpu_clk_75M (clk),
        .cpu_rst     (rst),
        .start_i     (start),
        .signed_i    (sgn),
        .dividend_i  (dvd),
        .divisor_i   (dvs),
        .flush_i     (flush),
        .stop_o      (stop),
        .ready_o     (ready),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the ready cycle.
    task automatic run_div(input string tag, input logic s,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi,
                           input int exp_stall, input int exp_cyc);
        int stalls;
        int rcyc;
        logic got;
        logic [31:0] glo;
        logic [31:0] ghi;
        stalls = 0;
        rcyc = 0;
        got = 1'b0;
        glo = '0;
        ghi = '0;
        start = 1'b1;
        sgn = s;
        dvd = a;
        dvs = b;
        for (int i = 1; i <= 60 && !got; i++) begin
            #1;
            if (stop) stalls++;
            if (ready) begin
                got = 1'b1;
                rcyc = i;
                glo = lo;
                ghi = hi;
            end
            @(negedge clk);
            start = 1'b0;
            dvd = 32'hDEAD_BEEF;
            dvs = 32'hDEAD_BEEF;
        end
        check({tag, "_ready"}, {31'b0, got}, 32'd1);
        check({tag, "_stall"}, stalls, exp_stall);
        check({tag, "_cyc"}, rcyc, exp_cyc);
        check({tag, "_lo"}, glo, exp_lo);
        check({tag, "_hi"}, ghi, exp_hi);
    endtask

    task automatic no_ready(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (ready || stop) seen++;
            @(negedge clk);
        end
        check({tag, "_quiet"}, seen, 0);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        sgn    = 1'b0;
        dvd    = '0;
        dvs    = '0;
        flush  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stop", {31'b0, stop}, 0);
        check("rst_ready", {31'b0, ready}, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 34);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 34);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
                32'hFFFF_FFFD, 32'd1, 33, 34);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000, 32'd0, 33, 34);
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h10,
                32'h0FFF_FFFF, 32'hF, 33, 34);
        run_div("div_5_0", 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 2, 3);
`ifdef DIV_EARLY_TERM_EN
        run_div("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1, 2);
`else
        run_div("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 33, 34);
`endif

        // Back-to-back: second start lands in the cycle after END
        run_div("b2b_a", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 33, 34);
        run_div("b2b_b", 1'b1, 32'hFFFF_FF9C, 32'd9,
                32'hFFFF_FFF5, 32'hFFFF_FFFF, 33, 34);

        // Flush in ON iteration 10 (cycle 12)
        start = 1'b1;
        sgn = 1'b0;
        dvd = 32'd1000;
        dvs = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stop", {31'b0, stop}, 0);
        check("flush_ready", {31'b0, ready}, 0);
        @(negedge clk);
        flush = 1'b0;
        no_ready("flush", 40);
        check("flush_lo_hold", lo, 32'hFFFF_FFF5);
        check("flush_hi_hold", hi, 32'hFFFF_FFFF);
        run_div("after_flush", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 34);

        // Flush together with start: not accepted
        start = 1'b1;
        flush = 1'b1;
        dvd = 32'd20;
        dvs = 32'd4;
        #1;
        check("fs_stop", {31'b0, stop}, 0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        no_ready("fs", 40);

        // Reset mid-ON
        start = 1'b1;
        dvd = 32'd100;
        dvs = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_stop", {31'b0, stop}, 0);
        check("mid_rst_ready", {31'b0, ready}, 0);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        @(negedge clk);
        no_ready("mid_rst", 40);
        run_div("after_rst", 1'b0, 32'd77, 32'd10, 32'd7, 32'd7, 33, 34);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
